// File: rtl/mac.sv
// Unsigned multiply-accumulate element: out accumulates opa*opb every clock.
// Optional build macro: MAC_SATURATE_EN (clamp to all-ones on overflow instead of wrapping).
module mac #(
    parameter int unsigned A_W   = 8,
    parameter int unsigned B_W   = 8,
    parameter int unsigned ACC_W = 16
) (
    output logic [ACC_W-1:0] out,
    input  logic [A_W-1:0]   opa,
    input  logic [B_W-1:0]   opb,
    input  logic             clk,
    input  logic             clr,
    input  logic             rst_n,
    output logic             ovf
);

    localparam int unsigned P_W = A_W + B_W;
    localparam int unsigned S_W = ACC_W + 1;

    // The accumulator must hold at least one full-width product.
    if (ACC_W < P_W) begin : g_bad_acc_w
        $error("mac: ACC_W must be >= A_W+B_W");
    end

    logic [P_W-1:0] prod_c;
    logic [S_W-1:0] sum_c;

    // Full-width product, then one carry bit of headroom above the accumulator.
    always_comb begin
        prod_c = P_W'(opa) * P_W'(opb);
        sum_c  = S_W'(out) + S_W'(prod_c);
    end

    // Accumulator and sticky overflow; clear takes priority over accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            out <= '0;
            ovf <= 1'b0;
        end else begin
`ifdef MAC_SATURATE_EN
            if (sum_c[ACC_W]) begin
                out <= '1;
            end else begin
                out <= sum_c[ACC_W-1:0];
            end
`else
            out <= sum_c[ACC_W-1:0];
`endif
            ovf <= ovf | sum_c[ACC_W];
        end
    end

endmodule

// File: tb/tb_mac.sv
// Directed self-checking bench for mac (default 8x8 -> 16-bit configuration).
module tb_mac;

    logic [15:0] out;
    logic [7:0]  opa;
    logic [7:0]  opb;
    logic        clk;
    logic        clr;
    logic        rst_n;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    mac #(.A_W(8), .B_W(8), .ACC_W(16)) dut (
        .out   (out),
        .opa   (opa),
        .opb   (opb),
        .clk   (clk),
        .clr   (clr),
        .rst_n (rst_n),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_sum [10];
        logic [15:0] exp_wrap2;
        logic [15:0] exp_hold;
        logic [15:0] exp_plus1;

        exp_sum = '{10, 30, 60, 100, 150, 210, 280, 360, 450, 550};
`ifdef MAC_SATURATE_EN
        exp_wrap2 = 16'd65535;
        exp_hold  = 16'd65535;
        exp_plus1 = 16'd65535;
`else
        exp_wrap2 = 16'd64514;
        exp_hold  = 16'd64514;
        exp_plus1 = 16'd64515;
`endif

        rst_n = 1'b0;
        clr   = 1'b0;
        opa   = 8'd0;
        opb   = 8'd0;
        #12;
        check("reset_out", 32'(out), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);

        // Build a nonzero value, then reset asynchronously mid-cycle.
        rst_n = 1'b1;
        opa = 8'd3;
        opb = 8'd4;
        step();
        check("pre_async_out", 32'(out), 32'd12);
        rst_n = 1'b0;
        #1;
        check("async_reset_out", 32'(out), 32'd0);
        check("async_reset_ovf", 32'(ovf), 32'd0);
        #1;
        rst_n = 1'b1;

        // Clear held with nonzero operands keeps the accumulator at zero.
        clr = 1'b1;
        opa = 8'd5;
        opb = 8'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("clr_hold_%0d", i), 32'(out), 32'd0);
        end

        // Running sum of k*10 for k = 1..10.
        clr = 1'b0;
        opb = 8'd10;
        for (int k = 1; k <= 10; k++) begin
            opa = 8'(k);
            step();
            check($sformatf("accum_%0d", k), 32'(out), 32'(exp_sum[k-1]));
        end
        check("accum_ovf", 32'(ovf), 32'd0);

        // Clear discards the operand product on the same edge.
        clr = 1'b1;
        opa = 8'd9;
        opb = 8'd9;
        step();
        check("clr_out", 32'(out), 32'd0);
        clr = 1'b0;

        // Zero operand holds the value.
        opa = 8'd0;
        opb = 8'd200;
        step();
        check("zero_op_hold", 32'(out), 32'd0);

        // Maximum product from zero, then overflow on the second edge.
        opa = 8'd255;
        opb = 8'd255;
        step();
        check("max_prod_out", 32'(out), 32'd65025);
        check("max_prod_ovf", 32'(ovf), 32'd0);
        step();
        check("wrap_out", 32'(out), 32'(exp_wrap2));
        check("wrap_ovf", 32'(ovf), 32'd1);

        // Overflow flag is sticky across later non-overflowing edges.
        opa = 8'd0;
        step();
        check("post_wrap_hold", 32'(out), 32'(exp_hold));
        check("sticky_ovf_a", 32'(ovf), 32'd1);
        opa = 8'd1;
        opb = 8'd1;
        step();
        check("post_wrap_plus1", 32'(out), 32'(exp_plus1));
        check("sticky_ovf_b", 32'(ovf), 32'd1);

        // Clear restores both the value and the flag.
        clr = 1'b1;
        step();
        check("clr_after_ovf_out", 32'(out), 32'd0);
        check("clr_after_ovf_ovf", 32'(ovf), 32'd0);

        // Reset asserted together with clear while accumulating.
        clr = 1'b0;
        opa = 8'd7;
        opb = 8'd6;
        step();
        check("pre_reset_clr_out", 32'(out), 32'd42);
        clr   = 1'b1;
        rst_n = 1'b0;
        step();
        check("reset_with_clr_out", 32'(out), 32'd0);
        rst_n = 1'b1;
        clr   = 1'b0;
        step();
        check("first_after_reset", 32'(out), 32'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
